// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: mode encodings,
// per-mode polynomial taps and the checker state type.
package prbs_pkg;

  localparam logic [2:0] MODE_PRBS7  = 3'd0;
  localparam logic [2:0] MODE_PRBS9  = 3'd1;
  localparam logic [2:0] MODE_PRBS15 = 3'd2;
  localparam logic [2:0] MODE_PRBS23 = 3'd3;
  localparam logic [2:0] MODE_PRBS31 = 3'd4;

  // x^N + x^M + 1, indexed by mode; codes 5..7 alias PRBS31
  localparam logic [4:0] PRBS_N [0:7] = '{5'd7, 5'd9, 5'd15, 5'd23,
                                          5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [4:0] PRBS_M [0:7] = '{5'd6, 5'd5, 5'd14, 5'd18,
                                          5'd28, 5'd28, 5'd28, 5'd28};

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

endpackage

// File: rtl/prbs_step.sv
// Combinational WIDTH-step Fibonacci LFSR advance. With EXT_FEED=0 the
// predicted bits are fed back (generator); with EXT_FEED=1 the feed bits are
// shifted in instead (self-synchronising checker prediction).
module prbs_step #(
  parameter int WIDTH    = 8,
  parameter bit EXT_FEED = 1'b0
) (
  input  logic [30:0]      state,
  input  logic [4:0]       tap_n,
  input  logic [4:0]       tap_m,
  input  logic [WIDTH-1:0] feed,
  output logic [WIDTH-1:0] bits,
  output logic [30:0]      state_next
);

  always_comb begin
    logic [30:0] s;
    logic        pred;
    s    = state;
    pred = 1'b0;
    bits = '0;
    // MSB is the oldest bit of the word, so it is processed first
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pred    = s[tap_n - 5'd1] ^ s[tap_m - 5'd1];
      bits[i] = pred;
      s       = {s[29:0], (EXT_FEED ? feed[i] : pred)};
    end
    state_next = s;
  end

endmodule

// File: rtl/prbs_gen_check.sv
// Parallel multi-mode PRBS generator plus self-synchronising checker with
// lock tracking and saturating bit-error count. Optional: PRBS_ERROR_INJECT_EN.
//
// state  | meaning
// HUNT   | waiting for LOCK_COUNT consecutive clean words; errors not counted
// LOCKED | errors accumulated; LOSS_COUNT consecutive errored words drop lock
module prbs_gen_check
  import prbs_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 8,
  parameter int ERR_WIDTH    = 32,
  parameter int LOCK_COUNT   = 16,
  parameter int LOSS_COUNT   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              mode,
  input  logic                    enable,
  output logic [OUTPUT_WIDTH-1:0] tx_data,
  output logic                    tx_valid,
  input  logic [OUTPUT_WIDTH-1:0] rx_data,
  input  logic                    rx_valid,
  input  logic                    clear_errors,
`ifdef PRBS_ERROR_INJECT_EN
  input  logic                    inject_error,
`endif
  output logic                    locked,
  output logic [ERR_WIDTH-1:0]    err_count,
  output logic                    err_word
);

  localparam int W  = OUTPUT_WIDTH;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam int PW = $clog2(W + 1);
  localparam int SW = ((ERR_WIDTH > PW) ? ERR_WIDTH : PW) + 1;

  localparam logic [GW-1:0]        GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0]        BAD_LAST  = BW'(LOSS_COUNT - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

  logic [2:0]     mode_q;
  logic           mode_chg;
  logic [4:0]     tap_n, tap_m;
  logic [30:0]    lfsr, lfsr_adv;
  logic [W-1:0]   gen_bits;
  logic [W-1:0]   flip;
  logic [30:0]    hist, hist_adv;
  logic [W-1:0]   pred_bits, err_vec, e_q;
  logic           chk_v;
  logic [PW-1:0]  pop;
  logic [SW-1:0]  sum;
  logic [ERR_WIDTH-1:0] acc;
  logic           word_bad;
  chk_state_t     state;
  logic [GW-1:0]  good_run;
  logic [BW-1:0]  bad_run;

  assign mode_chg = (mode != mode_q);
  assign tap_n    = PRBS_N[mode_q];
  assign tap_m    = PRBS_M[mode_q];

  prbs_step #(.WIDTH(W), .EXT_FEED(1'b0)) u_gen_step (
    .state      (lfsr),
    .tap_n      (tap_n),
    .tap_m      (tap_m),
    .feed       ('0),
    .bits       (gen_bits),
    .state_next (lfsr_adv)
  );

  prbs_step #(.WIDTH(W), .EXT_FEED(1'b1)) u_chk_step (
    .state      (hist),
    .tap_n      (tap_n),
    .tap_m      (tap_m),
    .feed       (rx_data),
    .bits       (pred_bits),
    .state_next (hist_adv)
  );

  assign err_vec = rx_data ^ pred_bits;

`ifdef PRBS_ERROR_INJECT_EN
  logic inj_q, inj_pend, inj_now;

  // a rising edge is consumed by the next word actually emitted
  assign inj_now = inj_pend | (inject_error & ~inj_q);
  assign flip    = inj_now ? (W'(1) << (W - 1)) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      inj_q    <= 1'b0;
      inj_pend <= 1'b0;
    end else begin
      inj_q <= inject_error;
      if (enable && !mode_chg) inj_pend <= 1'b0;
      else if (inj_now)        inj_pend <= 1'b1;
    end
  end
`else
  assign flip = '0;
`endif

  // generator; a mode change reseeds and emits no word that cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q   <= mode;
      lfsr     <= '1;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        lfsr     <= '1;
        tx_valid <= 1'b0;
      end else begin
        tx_valid <= enable;
        if (enable) begin
          lfsr    <= lfsr_adv;
          tx_data <= gen_bits ^ flip;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist     <= '0;
      e_q      <= '0;
      chk_v    <= 1'b0;
      err_word <= 1'b0;
    end else begin
      chk_v    <= rx_valid;
      err_word <= rx_valid & (|err_vec);
      if (rx_valid) begin
        hist <= hist_adv;
        e_q  <= err_vec;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PW'(e_q[i]);
  end

  assign word_bad = |e_q;
  assign sum      = SW'(err_count) + SW'(pop);
  assign acc      = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_WIDTH-1:0];
  assign locked   = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= HUNT;
      good_run  <= '0;
      bad_run   <= '0;
      err_count <= '0;
    end else begin
      if (clear_errors)
        err_count <= '0;
      else if (!mode_chg && chk_v && state == LOCKED)
        err_count <= acc;

      if (mode_chg) begin
        state    <= HUNT;
        good_run <= '0;
        bad_run  <= '0;
      end else if (chk_v) begin
        if (state == HUNT) begin
          if (word_bad) begin
            good_run <= '0;
          end else if (good_run == GOOD_LAST) begin
            state    <= LOCKED;
            good_run <= '0;
            bad_run  <= '0;
          end else begin
            good_run <= good_run + GW'(1);
          end
        end else begin
          if (!word_bad) begin
            bad_run <= '0;
          end else if (bad_run == BAD_LAST) begin
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
          end else begin
            bad_run <= bad_run + BW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_check.sv
// Self-checking bench for prbs_gen_check: bit-serial reference model, per-cycle
// scoreboard of expected outputs, plus directed checks on the headline cases.
module tb_prbs_gen_check;

  localparam int W  = 8;
  localparam int EW = 4;
  localparam int LC = 16;
  localparam int LS = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          enable = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          clear_errors = 1'b0;
`ifdef PRBS_ERROR_INJECT_EN
  logic          inject_error = 1'b0;
`endif
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          locked;
  logic [EW-1:0] err_count;
  logic          err_word;

  always #5 clock = ~clock;

  prbs_gen_check #(
    .OUTPUT_WIDTH (W),
    .ERR_WIDTH    (EW),
    .LOCK_COUNT   (LC),
    .LOSS_COUNT   (LS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .enable       (enable),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .clear_errors (clear_errors),
`ifdef PRBS_ERROR_INJECT_EN
    .inject_error (inject_error),
`endif
    .locked       (locked),
    .err_count    (err_count),
    .err_word     (err_word)
  );

  typedef struct {
    logic [W-1:0] tx;
    logic         txv;
    logic         lk;
    int           ec;
    logic         ew;
  } exp_t;

  exp_t sb[$];
  exp_t last_x;
  int   total = 0;
  int   passes = 0;

  // reference model state
  logic [30:0]  m_lfsr, m_hist;
  logic [W-1:0] m_tx;
  logic         m_txv, m_ew, m_lk, m_pv;
  logic [2:0]   m_mode_q;
  int           m_ppop, m_good, m_bad, m_err;
`ifdef PRBS_ERROR_INJECT_EN
  logic         m_inj_q, m_pend;
`endif

  function automatic int taps_n(input logic [2:0] md);
    case (md)
      3'd0: return 7;
      3'd1: return 9;
      3'd2: return 15;
      3'd3: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int taps_m(input logic [2:0] md);
    case (md)
      3'd0: return 6;
      3'd1: return 5;
      3'd2: return 14;
      3'd3: return 18;
      default: return 28;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  // advance the model across one clock edge using the inputs now applied
  task automatic model_edge();
    int n, mt, cnt;
    logic p, b, chg, inj_now;
    logic [W-1:0] w;
    if (!reset) begin
      m_mode_q = mode;
      m_lfsr = '1; m_tx = '0; m_txv = 1'b0;
      m_hist = '0; m_ew = 1'b0; m_pv = 1'b0; m_ppop = 0;
      m_lk = 1'b0; m_good = 0; m_bad = 0; m_err = 0;
`ifdef PRBS_ERROR_INJECT_EN
      m_inj_q = 1'b0; m_pend = 1'b0;
`endif
    end else begin
      n   = taps_n(m_mode_q);
      mt  = taps_m(m_mode_q);
      chg = (mode != m_mode_q);
      if (clear_errors) m_err = 0;
      else if (!chg && m_pv && m_lk) begin
        m_err = m_err + m_ppop;
        if (m_err > ERR_MAX) m_err = ERR_MAX;
      end
      if (chg) begin
        m_lk = 1'b0; m_good = 0; m_bad = 0;
      end else if (m_pv) begin
        if (!m_lk) begin
          if (m_ppop != 0) m_good = 0;
          else begin
            m_good++;
            if (m_good == LC) begin m_lk = 1'b1; m_good = 0; m_bad = 0; end
          end
        end else begin
          if (m_ppop == 0) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == LS) begin m_lk = 1'b0; m_good = 0; m_bad = 0; end
          end
        end
      end
      m_pv = rx_valid;
      m_ew = 1'b0;
      if (rx_valid) begin
        cnt = 0;
        for (int i = W - 1; i >= 0; i--) begin
          p = m_hist[n-1] ^ m_hist[mt-1];
          if (rx_data[i] !== p) cnt++;
          m_hist = {m_hist[29:0], rx_data[i]};
        end
        m_ppop = cnt;
        m_ew = (cnt != 0);
      end
      inj_now = 1'b0;
`ifdef PRBS_ERROR_INJECT_EN
      inj_now = m_pend | (inject_error & ~m_inj_q);
`endif
      if (chg) begin
        m_lfsr = '1; m_txv = 1'b0;
      end else begin
        m_txv = enable;
        if (enable) begin
          for (int i = W - 1; i >= 0; i--) begin
            b = m_lfsr[n-1] ^ m_lfsr[mt-1];
            w[i] = b;
            m_lfsr = {m_lfsr[29:0], b};
          end
          m_tx = w;
          m_tx[W-1] = m_tx[W-1] ^ inj_now;
        end
      end
`ifdef PRBS_ERROR_INJECT_EN
      if (enable && !chg) m_pend = 1'b0;
      else if (inj_now)   m_pend = 1'b1;
      m_inj_q = inject_error;
`endif
      m_mode_q = mode;
    end
  endtask

  task automatic tick();
    exp_t x;
    model_edge();
    x.tx = m_tx; x.txv = m_txv; x.lk = m_lk; x.ec = m_err; x.ew = m_ew;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    last_x = x;
    chk("tx_valid",  64'(tx_valid),  64'(x.txv));
    chk("tx_data",   64'(tx_data),   64'(x.tx));
    chk("locked",    64'(locked),    64'(x.lk));
    chk("err_count", 64'(err_count), 64'(x.ec));
    chk("err_word",  64'(err_word),  64'(x.ew));
  endtask

  task automatic loop_tick(input logic [W-1:0] mask, input bit inv, input bit clr);
    rx_data      = (inv ? ~tx_data : tx_data) ^ mask;
    rx_valid     = tx_valid;
    clear_errors = clr;
    tick();
    clear_errors = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!locked && n < 300) begin
      loop_tick('0, 1'b0, 1'b0);
      n++;
    end
    chk(tag, 64'(locked), 64'd1);
  endtask

  initial begin
    logic [W-1:0] w0;
    int snap;

    // reset held for three clocks
    for (int i = 0; i < 3; i++) tick();
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_tx_valid", 64'(tx_valid), 64'd0);

    // PRBS7 free-running: period of 127 words for an 8-bit word
    reset  = 1'b1;
    enable = 1'b1;
    w0     = '0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (i == 0) begin
        w0 = last_x.tx;
        chk("first_tx_valid", 64'(tx_valid), 64'd1);
      end
      if (i == 127) chk("prbs7_period", 64'(tx_data), 64'(w0));
    end

    // PRBS31 loopback: lock, then long clean run
    mode = 3'd4;
    loop_tick('0, 1'b0, 1'b0);
    chk("modechg_tx_valid", 64'(tx_valid), 64'd0);
    wait_lock("prbs31_lock");
    for (int i = 0; i < 10000; i++) loop_tick('0, 1'b0, 1'b0);
    chk("clean_err_count", 64'(err_count), 64'd0);
    chk("clean_locked", 64'(locked), 64'd1);

    // single flipped channel bit gives exactly three error bits
    snap = m_err;
    loop_tick(8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) loop_tick('0, 1'b0, 1'b0);
    chk("flip_err_count", 64'(err_count), 64'(snap + 3));
    chk("flip_locked", 64'(locked), 64'd1);

    // inverted data: counter clamps at 15, lock lost after 4 errored words
    for (int i = 0; i < 3; i++) loop_tick('0, 1'b1, 1'b0);
    chk("inv_still_locked", 64'(locked), 64'd1);
    for (int i = 0; i < 3; i++) loop_tick('0, 1'b1, 1'b0);
    chk("sat_err_count", 64'(err_count), 64'd15);
    chk("inv_lock_lost", 64'(locked), 64'd0);
    for (int i = 0; i < 4; i++) loop_tick('0, 1'b1, 1'b0);
    chk("sat_hold", 64'(err_count), 64'd15);

    // relock, then mode change drops lock on the next edge
    wait_lock("prbs31_relock");
    mode = 3'd2;
    loop_tick('0, 1'b0, 1'b0);
    chk("modechg_unlock", 64'(locked), 64'd0);
    chk("modechg_keeps_err", 64'(err_count), 64'd15);
    wait_lock("prbs15_lock");

    // clear_errors wins over accumulation of an errored word
    loop_tick(8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) loop_tick('0, 1'b0, 1'b1);
    chk("clear_err_count", 64'(err_count), 64'd0);
    chk("clear_locked", 64'(locked), 64'd1);

`ifdef PRBS_ERROR_INJECT_EN
    snap = m_err;
    inject_error = 1'b1;
    loop_tick('0, 1'b0, 1'b0);
    inject_error = 1'b0;
    for (int i = 0; i < 8; i++) loop_tick('0, 1'b0, 1'b0);
    chk("inject_err_count", 64'(err_count), 64'(snap + 3));
    chk("inject_locked", 64'(locked), 64'd1);
`endif

    // reset mid-stream with enable and rx_valid high
    for (int i = 0; i < 4; i++) loop_tick('0, 1'b0, 1'b0);
    reset = 1'b0;
    loop_tick(8'hff, 1'b0, 1'b0);
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_tx_data", 64'(tx_data), 64'd0);
    chk("midrst_locked", 64'(locked), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    chk("midrst_err_word", 64'(err_word), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
